// File: rtl/gpio_chaser_if.sv
// Control/status bundle between the register block (master) and the GPIO chaser (slave).
interface gpio_chaser_if #(
    parameter int unsigned NUM_PINS   = 34,
    parameter int unsigned PRESCALE_W = 14,
    parameter int unsigned POS_W      = $clog2(NUM_PINS)
);
    logic                  enable;
    logic                  stop;
    logic [1:0]            mode;
    logic [PRESCALE_W-1:0] prescaler;
    logic [NUM_PINS-1:0]   gpio;
    logic [POS_W-1:0]      position;
    logic                  busy;
    logic                  done;

    modport master (
        output enable, stop, mode, prescaler,
        input  gpio, position, busy, done
    );

    modport slave (
        input  enable, stop, mode, prescaler,
        output gpio, position, busy, done
    );
endinterface

// File: rtl/gpio_chaser.sv
// One-hot GPIO sequencer: steps a single lit pin through NUM_PINS outputs on a
// programmable period, in one-shot forward/reverse, continuous or ping-pong order.
module gpio_chaser #(
    parameter int unsigned NUM_PINS       = 34,
    parameter int unsigned PRESCALE_W     = 14,
    parameter int unsigned TICKS_PER_UNIT = 10000
) (
    input logic          clk,
    input logic          rst,
    gpio_chaser_if.slave bus
);
    localparam int unsigned POS_W = $clog2(NUM_PINS);
    localparam int unsigned CNT_W = PRESCALE_W + $clog2(TICKS_PER_UNIT) + 1;

    localparam logic [POS_W-1:0]    LAST_POS = POS_W'(NUM_PINS - 1);
    localparam logic [POS_W-1:0]    ONE_POS  = POS_W'(1);
    localparam logic [CNT_W-1:0]    ONE_CNT  = CNT_W'(1);
    localparam logic [NUM_PINS-1:0] ONE_HOT0 = NUM_PINS'(1);

    localparam logic [1:0] MODE_ONCE_FWD = 2'b00;
    localparam logic [1:0] MODE_CONT_FWD = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_ONCE_REV = 2'b11;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic                  dir_down_q, dir_down_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_PINS-1:0]   gpio_q, gpio_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [CNT_W-1:0] period;
    logic             last_tick;

    // Full-width product: the counter never truncates the step period.
    assign period    = CNT_W'(pre_q) * CNT_W'(TICKS_PER_UNIT);
    assign last_tick = (cnt_q == period - ONE_CNT);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pre_d      = pre_q;
        pos_d      = pos_q;
        dir_down_d = dir_down_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                pos_d = '0;
                cnt_d = '0;
                if (!bus.stop && bus.enable && (bus.prescaler != '0)) begin
                    state_d    = StRun;
                    mode_d     = bus.mode;
                    pre_d      = bus.prescaler;
                    pos_d      = (bus.mode == MODE_ONCE_REV) ? LAST_POS : '0;
                    dir_down_d = (bus.mode == MODE_ONCE_REV);
                end
            end
            StRun: begin
                if (bus.stop) begin
                    state_d = StIdle;
                    pos_d   = '0;
                    cnt_d   = '0;
                end else if (bus.enable) begin
                    cnt_d = cnt_q + ONE_CNT;
                    if (last_tick) begin
                        cnt_d = '0;
                        pre_d = bus.prescaler;
                        if (bus.prescaler == '0) begin
                            // A zero period cannot be counted; abort quietly.
                            state_d = StIdle;
                            pos_d   = '0;
                        end else begin
                            unique case (mode_q)
                                MODE_ONCE_FWD: begin
                                    if (pos_q == LAST_POS) begin
                                        state_d = StIdle;
                                        pos_d   = '0;
                                        done_d  = 1'b1;
                                    end else begin
                                        pos_d = pos_q + ONE_POS;
                                    end
                                end
                                MODE_CONT_FWD: begin
                                    if (pos_q == LAST_POS) begin
                                        pos_d  = '0;
                                        done_d = 1'b1;
                                    end else begin
                                        pos_d = pos_q + ONE_POS;
                                    end
                                end
                                MODE_PINGPONG: begin
                                    if (!dir_down_q) begin
                                        pos_d = pos_q + ONE_POS;
                                        if (pos_d == LAST_POS) dir_down_d = 1'b1;
                                    end else begin
                                        pos_d = pos_q - ONE_POS;
                                        if (pos_d == '0) begin
                                            dir_down_d = 1'b0;
                                            done_d     = 1'b1;
                                        end
                                    end
                                end
                                MODE_ONCE_REV: begin
                                    if (pos_q == '0) begin
                                        state_d = StIdle;
                                        done_d  = 1'b1;
                                    end else begin
                                        pos_d = pos_q - ONE_POS;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        gpio_d = (state_d == StRun) ? (ONE_HOT0 << pos_d) : '0;
        busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= '0;
            pre_q      <= '0;
            pos_q      <= '0;
            dir_down_q <= 1'b0;
            cnt_q      <= '0;
            gpio_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pre_q      <= pre_d;
            pos_q      <= pos_d;
            dir_down_q <= dir_down_d;
            cnt_q      <= cnt_d;
            gpio_q     <= gpio_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.gpio     = gpio_q;
    assign bus.position = pos_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_gpio_chaser.sv
// Bench for gpio_chaser: step-count reference model checked every cycle, plus directed
// literal expectations for the documented sequences.
module tb_gpio_chaser;
    localparam int NP  = 4;
    localparam int TPU = 2;
    localparam int PW  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpio_chaser_if #(.NUM_PINS(NP), .PRESCALE_W(PW)) bus ();

    gpio_chaser #(
        .NUM_PINS(NP),
        .PRESCALE_W(PW),
        .TICKS_PER_UNIT(TPU)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: k counts completed steps since start; left counts enabled cycles still owed
    // to the current pin. The lit pin is derived from (mode, k) arithmetically.
    typedef struct packed {
        bit       run;
        bit [1:0] mode;
        int       k;
        int       left;
        bit       done;
    } mdl_t;

    mdl_t m = '0;

    function automatic mdl_t step(mdl_t c, bit r, bit en, bit st, bit [1:0] md, int ps);
        mdl_t n = c;
        n.done = 1'b0;
        if (r) return '0;
        if (!c.run) begin
            if (!st && en && ps != 0) begin
                n.run  = 1'b1;
                n.mode = md;
                n.k    = 0;
                n.left = ps * TPU;
            end
        end else if (st) begin
            n.run = 1'b0;
        end else if (en) begin
            n.left = c.left - 1;
            if (n.left == 0) begin
                if (ps == 0) begin
                    n.run = 1'b0;
                end else begin
                    n.k    = c.k + 1;
                    n.left = ps * TPU;
                    case (c.mode)
                        2'd0, 2'd3: if (n.k == NP) begin n.run = 1'b0; n.done = 1'b1; end
                        2'd1: if (n.k % NP == 0) n.done = 1'b1;
                        default: if (n.k % (2 * (NP - 1)) == 0) n.done = 1'b1;
                    endcase
                end
            end
        end
        return n;
    endfunction

    function automatic int pos_of(mdl_t c);
        int t;
        case (c.mode)
            2'd0: return c.k;
            2'd1: return c.k % NP;
            2'd2: begin
                t = c.k % (2 * (NP - 1));
                return (t < NP) ? t : 2 * (NP - 1) - t;
            end
            default: return NP - 1 - c.k;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk)
        m <= step(m, rst, bus.enable, bus.stop, bus.mode, int'(bus.prescaler));

    always @(negedge clk) begin
        chk("gpio",     32'(bus.gpio),     m.run ? (32'd1 << pos_of(m)) : 32'd0);
        chk("position", 32'(bus.position), m.run ? 32'(pos_of(m)) : 32'd0);
        chk("busy",     32'(bus.busy),     32'(m.run));
        chk("done",     32'(bus.done),     32'(m.done));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_seq[10] = '{1, 1, 2, 2, 4, 4, 8, 8, 0, 1};
    int pp[8]       = '{0, 1, 2, 3, 2, 1, 0, 1};

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.stop = 1'b0;
        bus.mode = 2'b00;
        bus.prescaler = '0;
        tick();
        tick();
        chk("rst_gpio", 32'(bus.gpio), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_pos",  32'(bus.position), 0);
        chk("rst_done", 32'(bus.done), 0);

        // One-shot forward, then automatic restart with enable still high.
        rst = 1'b0;
        bus.mode = 2'b00;
        bus.prescaler = 4'd1;
        bus.enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fwd_seq", 32'(bus.gpio), 32'(exp_seq[i]));
            if (i == 8) begin
                chk("fwd_done", 32'(bus.done), 1);
                chk("fwd_done_busy", 32'(bus.busy), 0);
            end
        end
        bus.stop = 1'b1;
        bus.enable = 1'b0;
        tick();
        chk("stop_busy", 32'(bus.busy), 0);
        bus.enable = 1'b1;
        tick();
        tick();
        chk("stop_en_idle", 32'(bus.busy), 0);
        bus.stop = 1'b0;
        bus.prescaler = 4'd0;
        tick();
        tick();
        chk("pre0_idle", 32'(bus.busy), 0);

        // One-shot reverse with a mid-step prescaler change, then a zero re-latch.
        bus.mode = 2'b11;
        bus.prescaler = 4'd1;
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (t == 1) bus.prescaler = 4'd3;
            if (t == 2) chk("rev_pos3", 32'(bus.position), 3);
            if (t == 3 || t == 8) chk("rev_pos2", 32'(bus.position), 2);
            if (t == 9) begin
                chk("rev_pos1", 32'(bus.position), 1);
                bus.prescaler = 4'd0;
            end
            if (t == 14) chk("rev_hold", 32'(bus.busy), 1);
            if (t == 15) begin
                chk("pre0_step_busy", 32'(bus.busy), 0);
                chk("pre0_step_done", 32'(bus.done), 0);
            end
        end

        // Reset mid-run and restart.
        bus.mode = 2'b01;
        bus.prescaler = 4'd1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_gpio", 32'(bus.gpio), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        tick();
        chk("restart_gpio", 32'(bus.gpio), 1);
        chk("restart_busy", 32'(bus.busy), 1);

        // Ping-pong with prescaler 2: four cycles per pin.
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.mode = 2'b10;
        bus.prescaler = 4'd2;
        for (int t = 1; t <= 29; t++) begin
            tick();
            if (t % 4 == 1) chk("pp_pos", 32'(bus.position), 32'(pp[(t - 1) / 4]));
            if (t == 25) chk("pp_done", 32'(bus.done), 1);
        end

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.stop = ($urandom_range(0, 49) == 0);
            bus.enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom);
            if ($urandom_range(0, 29) == 0) bus.prescaler = 4'($urandom_range(0, 3));
            if (bus.prescaler == 4'd0 && $urandom_range(0, 3) == 0) bus.prescaler = 4'd1;
            tick();
        end
        rst = 1'b0;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
